// File: rtl/coin_controller.sv
// coin_controller -- owns the single coin in the two-player game.
//
// On each frame tick the coin is tested for overlap against both Marios.
// A hit credits the collecting player (ties go to player 0), pulses collect
// and hides the coin off-screen. After RESPAWN_FRAMES ticks the coin is
// re-placed at a legal, Mario-free position chosen by a free-running LFSR.
// If no legal candidate turns up in MAX_TRIES cycles, it falls back to
// INIT_X/INIT_Y. When a score reaches WIN_SCORE the block freezes in
// GAME_OVER until reset.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   frame_tick            one-cycle pulse per video frame
//   mario_x/y, mario_x1/y1  player 0 / player 1 position (lower-left corner)
//   coin_x, coin_y        registered coin position (lower-left corner)
//   score0, score1        registered player scores
//   collect               one-cycle pulse per collection
//   game_over, winner     sticky end-of-game flag and winning player
module coin_controller #(
  parameter int W_MARIO        = 16,
  parameter int H_MARIO        = 16,
  parameter int W_COIN         = 8,
  parameter int H_COIN         = 8,
  parameter int X_MIN          = 10,
  parameter int X_MAX          = 580,
  parameter int Y_MIN          = 0,
  parameter int Y_MAX          = 200,
  parameter int INIT_X         = 300,
  parameter int INIT_Y         = 100,
  parameter int HIDDEN_X       = 1000,
  parameter int RESPAWN_FRAMES = 60,
  parameter int WIN_SCORE      = 10,
  parameter int MAX_TRIES      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [9:0] mario_x,
  input  logic [9:0] mario_y,
  input  logic [9:0] mario_x1,
  input  logic [9:0] mario_y1,
  output logic [9:0] coin_x,
  output logic [9:0] coin_y,
  output logic [7:0] score0,
  output logic [7:0] score1,
  output logic       collect,
  output logic       game_over,
  output logic       winner
);

  localparam int TW = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'd0,
    ST_COLLECTED = 2'd1,
    ST_PLACE     = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [15:0]     lfsr, lfsr_nx;
  logic [7:0]      frame_cnt, frame_cnt_nx;
  logic [TW-1:0]   tries, tries_nx;
  logic [9:0]      coin_x_nx, coin_y_nx;
  logic [7:0]      score0_nx, score1_nx;
  logic            collect_nx, game_over_nx, winner_nx;
  logic            hit0, hit1, cand_ok;
  logic [9:0]      cand_x, cand_y;

  // Rectangle overlap in 11 bits so the sums never wrap; strict compares
  // mean edge-touching rectangles do not overlap.
  function automatic logic overlap(input logic [9:0] cx, input logic [9:0] cy,
                                   input logic [9:0] px, input logic [9:0] py);
    logic [10:0] cxw, cyw, pxw, pyw;
    cxw = {1'b0, cx};
    cyw = {1'b0, cy};
    pxw = {1'b0, px};
    pyw = {1'b0, py};
    overlap = (cxw < pxw + 11'(W_MARIO)) && (pxw < cxw + 11'(W_COIN)) &&
              (cyw < pyw + 11'(H_MARIO)) && (pyw < cyw + 11'(H_COIN));
  endfunction

  // Inclusive range test as one unsigned compare: values below lo wrap to
  // a large offset, which avoids a constant compare when lo is zero.
  function automatic logic in_range(input logic [9:0] v, input logic [10:0] lo,
                                    input logic [10:0] hi);
    logic [10:0] off;
    off      = {1'b0, v} - lo;
    in_range = (off <= (hi - lo));
  endfunction

  assign hit0    = overlap(coin_x, coin_y, mario_x, mario_y);
  assign hit1    = overlap(coin_x, coin_y, mario_x1, mario_y1);
  assign cand_x  = lfsr[9:0];
  assign cand_y  = {2'b00, lfsr[15:8]};
  assign cand_ok = in_range(cand_x, 11'(X_MIN), 11'(X_MAX)) &&
                   in_range(cand_y, 11'(Y_MIN), 11'(Y_MAX)) &&
                   !overlap(cand_x, cand_y, mario_x, mario_y) &&
                   !overlap(cand_x, cand_y, mario_x1, mario_y1);

  // Fibonacci LFSR, taps 16,14,13,11; free-running in every state.
  assign lfsr_nx = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Next-state and next-output logic for the coin FSM.
  always_comb begin
    state_nx     = state;
    frame_cnt_nx = frame_cnt;
    tries_nx     = tries;
    coin_x_nx    = coin_x;
    coin_y_nx    = coin_y;
    score0_nx    = score0;
    score1_nx    = score1;
    collect_nx   = 1'b0;
    game_over_nx = game_over;
    winner_nx    = winner;
    case (state)
      ST_ACTIVE: begin
        if (frame_tick && (hit0 || hit1)) begin
          collect_nx = 1'b1;
          coin_x_nx  = 10'(HIDDEN_X);
          if (hit0) begin
            score0_nx = score0 + 8'd1;
          end else begin
            score1_nx = score1 + 8'd1;
          end
          if ((hit0 && (score0_nx == 8'(WIN_SCORE))) ||
              (!hit0 && (score1_nx == 8'(WIN_SCORE)))) begin
            state_nx     = ST_GAME_OVER;
            game_over_nx = 1'b1;
            winner_nx    = !hit0;
          end else begin
            state_nx     = ST_COLLECTED;
            frame_cnt_nx = 8'd0;
          end
        end else begin
          state_nx = ST_ACTIVE;
        end
      end
      ST_COLLECTED: begin
        if (frame_tick) begin
          if (frame_cnt == 8'(RESPAWN_FRAMES - 1)) begin
            state_nx = ST_PLACE;
            tries_nx = {TW{1'b0}};
          end else begin
            frame_cnt_nx = frame_cnt + 8'd1;
          end
        end else begin
          frame_cnt_nx = frame_cnt;
        end
      end
      ST_PLACE: begin
        if (cand_ok) begin
          coin_x_nx = cand_x;
          coin_y_nx = cand_y;
          state_nx  = ST_ACTIVE;
        end else if (tries == TW'(MAX_TRIES - 1)) begin
          // Last allowed reject: fall back without any overlap check.
          coin_x_nx = 10'(INIT_X);
          coin_y_nx = 10'(INIT_Y);
          state_nx  = ST_ACTIVE;
        end else begin
          tries_nx = tries + TW'(1);
        end
      end
      ST_GAME_OVER: begin
        state_nx = ST_GAME_OVER;
      end
      default: begin
        state_nx = ST_ACTIVE;
      end
    endcase
  end

  // State, counters, LFSR and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ACTIVE;
      lfsr      <= 16'hACE1;
      frame_cnt <= 8'd0;
      tries     <= {TW{1'b0}};
      coin_x    <= 10'(INIT_X);
      coin_y    <= 10'(INIT_Y);
      score0    <= 8'd0;
      score1    <= 8'd0;
      collect   <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      state     <= state_nx;
      lfsr      <= lfsr_nx;
      frame_cnt <= frame_cnt_nx;
      tries     <= tries_nx;
      coin_x    <= coin_x_nx;
      coin_y    <= coin_y_nx;
      score0    <= score0_nx;
      score1    <= score1_nx;
      collect   <= collect_nx;
      game_over <= game_over_nx;
      winner    <= winner_nx;
    end
  end

endmodule

// File: tb/tb_coin_controller.sv
// Testbench for coin_controller: directed scenarios plus a randomized run
// checked against a behavioural game model. A second instance with an
// impossible placement window exercises the fallback path.
module tb_coin_controller;

  logic       clk, rst, frame_tick;
  logic [9:0] mario_x, mario_y, mario_x1, mario_y1;
  logic [9:0] coin_x, coin_y;
  logic [7:0] score0, score1;
  logic       collect, game_over, winner;

  logic       f_rst, f_tick;
  logic [9:0] f_mx, f_my, f_mx1, f_my1;
  logic [9:0] f_coin_x, f_coin_y;
  logic [7:0] f_score0, f_score1;
  logic       f_collect, f_game_over, f_winner;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the main instance.
  // m_phase: 0 coin shown, 1 hidden counting frames, 2 looking for a spot, 3 game finished
  int m_cx, m_cy, m_s0, m_s1, m_col, m_over, m_win, m_lfsr, m_phase, m_frames, m_tries;

  coin_controller dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .mario_x(mario_x), .mario_y(mario_y), .mario_x1(mario_x1), .mario_y1(mario_y1),
    .coin_x(coin_x), .coin_y(coin_y), .score0(score0), .score1(score1),
    .collect(collect), .game_over(game_over), .winner(winner)
  );

  coin_controller #(.X_MIN(5), .X_MAX(5), .Y_MIN(5), .Y_MAX(5)) fdut (
    .clk(clk), .rst(f_rst), .frame_tick(f_tick),
    .mario_x(f_mx), .mario_y(f_my), .mario_x1(f_mx1), .mario_y1(f_my1),
    .coin_x(f_coin_x), .coin_y(f_coin_y), .score0(f_score0), .score1(f_score1),
    .collect(f_collect), .game_over(f_game_over), .winner(f_winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit hit(int cx, int cy, int px, int py);
    return (cx < px + 16) && (px < cx + 8) && (cy < py + 16) && (py < cy + 8);
  endfunction

  function automatic logic [9:0] clamp10(int v);
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return 10'(v);
  endfunction

  task automatic model_reset();
    m_cx = 300; m_cy = 100; m_s0 = 0; m_s1 = 0; m_col = 0; m_over = 0; m_win = 0;
    m_lfsr = 'hACE1; m_phase = 0; m_frames = 0; m_tries = 0;
  endtask

  // Advance one clock: the model decides from the inputs in force before the edge.
  task automatic step();
    int n_cx, n_cy, n_s0, n_s1, n_col, n_over, n_win, n_phase, n_frames, n_tries;
    int c_x, c_y, fb;
    bit h0, h1;
    n_cx = m_cx; n_cy = m_cy; n_s0 = m_s0; n_s1 = m_s1; n_col = 0; n_over = m_over;
    n_win = m_win; n_phase = m_phase; n_frames = m_frames; n_tries = m_tries;
    if (m_phase == 0 && frame_tick) begin
      h0 = hit(m_cx, m_cy, int'(mario_x), int'(mario_y));
      h1 = hit(m_cx, m_cy, int'(mario_x1), int'(mario_y1));
      if (h0 || h1) begin
        n_col = 1; n_cx = 1000;
        if (h0) n_s0 = m_s0 + 1; else n_s1 = m_s1 + 1;
        if (n_s0 == 10 || n_s1 == 10) begin
          n_over = 1; n_win = h0 ? 0 : 1; n_phase = 3;
        end else begin
          n_phase = 1; n_frames = 0;
        end
      end
    end else if (m_phase == 1 && frame_tick) begin
      n_frames = m_frames + 1;
      if (n_frames == 60) begin n_phase = 2; n_tries = 0; end
    end else if (m_phase == 2) begin
      c_x = m_lfsr % 1024;
      c_y = (m_lfsr / 256) % 256;
      if (c_x >= 10 && c_x <= 580 && c_y <= 200 &&
          !hit(c_x, c_y, int'(mario_x), int'(mario_y)) &&
          !hit(c_x, c_y, int'(mario_x1), int'(mario_y1))) begin
        n_cx = c_x; n_cy = c_y; n_phase = 0;
      end else begin
        n_tries = m_tries + 1;
        if (n_tries == 64) begin n_cx = 300; n_cy = 100; n_phase = 0; end
      end
    end
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    @(posedge clk);
    #1;
    m_cx = n_cx; m_cy = n_cy; m_s0 = n_s0; m_s1 = n_s1; m_col = n_col; m_over = n_over;
    m_win = n_win; m_phase = n_phase; m_frames = n_frames; m_tries = n_tries;
    m_lfsr = ((m_lfsr * 2) % 65536) | fb;
  endtask

  task automatic main_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    main_reset();
    total++; if (coin_x !== 10'd300) begin bad++; $display("FAIL reset_coin_x got=%0d want=300", coin_x); end
    total++; if (coin_y !== 10'd100) begin bad++; $display("FAIL reset_coin_y got=%0d want=100", coin_y); end
    total++; if (score0 !== 8'd0 || score1 !== 8'd0) begin bad++; $display("FAIL reset_scores got=%0d/%0d want=0/0", score0, score1); end
    total++; if ({collect, game_over, winner} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {collect, game_over, winner}); end
  endtask

  task automatic test_no_overlap();
    mario_x = 10'd0; mario_y = 10'd0; mario_x1 = 10'd0; mario_y1 = 10'd0;
    for (int i = 0; i < 10; i++) begin
      frame_tick = (i % 2 == 0);
      step();
      total++; if (collect !== 1'b0) begin bad++; $display("FAIL no_overlap_collect cyc=%0d got=%b want=0", i, collect); end
    end
    frame_tick = 1'b0;
    total++; if (coin_x !== 10'd300 || coin_y !== 10'd100) begin bad++; $display("FAIL no_overlap_coin got=(%0d,%0d) want=(300,100)", coin_x, coin_y); end
    total++; if (score0 !== 8'd0 || score1 !== 8'd0) begin bad++; $display("FAIL no_overlap_scores got=%0d/%0d want=0/0", score0, score1); end
  endtask

  task automatic test_edge_touch();
    int px[3] = '{284, 300, 308};
    int py[3] = '{100, 84, 100};
    for (int i = 0; i < 3; i++) begin
      mario_x = 10'(px[i]); mario_y = 10'(py[i]);
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      total++; if (collect !== 1'b0 || score0 !== 8'd0) begin bad++; $display("FAIL edge_touch_%0d got collect=%b score0=%0d want 0/0", i, collect, score0); end
      step();
    end
    mario_x = 10'd0; mario_y = 10'd0;
  endtask

  task automatic test_p1_collect();
    int cyc;
    mario_x1 = 10'd296; mario_y1 = 10'd96;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    total++; if (score1 !== 8'd1 || score0 !== 8'd0) begin bad++; $display("FAIL p1_score got=%0d/%0d want=0/1", score0, score1); end
    total++; if (coin_x !== 10'd1000) begin bad++; $display("FAIL p1_hidden got=%0d want=1000", coin_x); end
    total++; if (collect !== 1'b1) begin bad++; $display("FAIL p1_collect_rise got=%b want=1", collect); end
    step();
    total++; if (collect !== 1'b0) begin bad++; $display("FAIL p1_collect_fall got=%b want=0", collect); end
    for (int i = 1; i <= 60; i++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      if (i == 59) begin
        total++; if (coin_x !== 10'd1000) begin bad++; $display("FAIL p1_early_respawn got=%0d want=1000", coin_x); end
      end
      if (i < 60) step();
    end
    cyc = 0;
    while (m_phase != 0 && cyc < 100) begin
      step(); cyc++;
    end
    total++; if (m_phase != 0 || cyc > 64) begin bad++; $display("FAIL p1_respawn_time got=%0d cycles want<=64", cyc); end
    total++; if (coin_x !== 10'(m_cx) || coin_y !== 10'(m_cy)) begin bad++; $display("FAIL p1_respawn_pos got=(%0d,%0d) want=(%0d,%0d)", coin_x, coin_y, m_cx, m_cy); end
    total++; if (coin_x < 10'd10 || coin_x > 10'd580 || coin_y > 10'd200) begin bad++; $display("FAIL p1_respawn_range got=(%0d,%0d) want x in 10..580, y in 0..200", coin_x, coin_y); end
  endtask

  task automatic test_tie();
    main_reset();
    mario_x = 10'd300; mario_y = 10'd100; mario_x1 = 10'd300; mario_y1 = 10'd100;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    total++; if (score0 !== 8'd1 || score1 !== 8'd0 || collect !== 1'b1) begin bad++; $display("FAIL tie got s0=%0d s1=%0d col=%b want 1/0/1", score0, score1, collect); end
    mario_x = 10'd0; mario_y = 10'd0; mario_x1 = 10'd0; mario_y1 = 10'd0;
  endtask

  task automatic test_random();
    int p, v;
    main_reset();
    for (int i = 0; i < 1500; i++) begin
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) begin
        p = $urandom_range(0, 1);
        if ($urandom_range(0, 3) != 0) begin
          v = m_cx + int'($urandom_range(0, 40)) - 20;
          if (p == 0) mario_x = clamp10(v); else mario_x1 = clamp10(v);
          v = m_cy + int'($urandom_range(0, 40)) - 20;
          if (p == 0) mario_y = clamp10(v); else mario_y1 = clamp10(v);
        end else begin
          if (p == 0) begin mario_x = 10'($urandom_range(0, 639)); mario_y = 10'($urandom_range(0, 255)); end
          else begin mario_x1 = 10'($urandom_range(0, 639)); mario_y1 = 10'($urandom_range(0, 255)); end
        end
      end
      step();
      total++;
      if (coin_x !== 10'(m_cx) || coin_y !== 10'(m_cy) || score0 !== 8'(m_s0) || score1 !== 8'(m_s1) ||
          collect !== 1'(m_col) || game_over !== 1'(m_over) || winner !== 1'(m_win)) begin
        bad++;
        $display("FAIL random cyc=%0d got coin=(%0d,%0d) s=%0d/%0d col=%b go=%b w=%b want coin=(%0d,%0d) s=%0d/%0d col=%0d go=%0d w=%0d",
                 i, coin_x, coin_y, score0, score1, collect, game_over, winner, m_cx, m_cy, m_s0, m_s1, m_col, m_over, m_win);
      end
    end
    frame_tick = 1'b0;
  endtask

  task automatic test_win();
    int cyc;
    main_reset();
    mario_x1 = 10'd0; mario_y1 = 10'd0;
    for (int k = 1; k <= 10; k++) begin
      mario_x = 10'(m_cx); mario_y = 10'(m_cy);
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      total++; if (score0 !== 8'(k) || collect !== 1'b1) begin bad++; $display("FAIL win_step_%0d got s0=%0d col=%b want %0d/1", k, score0, collect, k); end
      total++; if (game_over !== (k == 10)) begin bad++; $display("FAIL win_go_%0d got=%b want=%0d", k, game_over, (k == 10)); end
      if (k < 10) begin
        cyc = 0;
        while (m_phase != 0 && cyc < 400) begin
          frame_tick = (cyc % 2 == 0); step(); cyc++;
        end
        frame_tick = 1'b0;
        total++; if (m_phase != 0 || coin_x !== 10'(m_cx) || coin_y !== 10'(m_cy)) begin bad++; $display("FAIL win_respawn_%0d got=(%0d,%0d) want=(%0d,%0d)", k, coin_x, coin_y, m_cx, m_cy); end
      end
    end
    total++; if (winner !== 1'b0) begin bad++; $display("FAIL win_winner got=%b want=0", winner); end
    mario_x = 10'd1000; mario_y = 10'(m_cy);
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      total++; if (score0 !== 8'd10 || coin_x !== 10'd1000 || collect !== 1'b0 || game_over !== 1'b1) begin bad++; $display("FAIL win_frozen_%0d got s0=%0d x=%0d col=%b go=%b want 10/1000/0/1", i, score0, coin_x, collect, game_over); end
    end
  endtask

  task automatic test_fallback();
    f_rst = 1'b0;
    f_mx = 10'd300; f_my = 10'd100; f_mx1 = 10'd0; f_my1 = 10'd0;
    f_tick = 1'b1; step(); f_tick = 1'b0;
    total++; if (f_collect !== 1'b1 || f_score0 !== 8'd1 || f_coin_x !== 10'd1000) begin bad++; $display("FAIL fb_collect got col=%b s0=%0d x=%0d want 1/1/1000", f_collect, f_score0, f_coin_x); end
    f_mx = 10'd0; f_my = 10'd0;
    for (int i = 1; i <= 60; i++) begin
      f_tick = 1'b1; step(); f_tick = 1'b0;
      if (i < 60) step();
    end
    for (int k = 1; k <= 63; k++) step();
    total++; if (f_coin_x !== 10'd1000) begin bad++; $display("FAIL fb_63_rejects got=%0d want=1000", f_coin_x); end
    step();
    total++; if (f_coin_x !== 10'd300 || f_coin_y !== 10'd100) begin bad++; $display("FAIL fb_fallback_pos got=(%0d,%0d) want=(300,100)", f_coin_x, f_coin_y); end
    // Second run: reset while the collect pulse is high and the coin is hidden.
    f_mx = 10'd300; f_my = 10'd100;
    f_tick = 1'b1; step(); f_tick = 1'b0;
    total++; if (f_collect !== 1'b1 || f_score0 !== 8'd2) begin bad++; $display("FAIL fb_second_collect got col=%b s0=%0d want 1/2", f_collect, f_score0); end
    f_rst = 1'b1;
    #1;
    total++; if (f_coin_x !== 10'd300 || f_coin_y !== 10'd100) begin bad++; $display("FAIL fb_rst_coin got=(%0d,%0d) want=(300,100)", f_coin_x, f_coin_y); end
    total++; if (f_score0 !== 8'd0 || f_score1 !== 8'd0) begin bad++; $display("FAIL fb_rst_scores got=%0d/%0d want=0/0", f_score0, f_score1); end
    total++; if ({f_collect, f_game_over, f_winner} !== 3'b000) begin bad++; $display("FAIL fb_rst_flags got=%b want=000", {f_collect, f_game_over, f_winner}); end
    step();
    f_rst = 1'b0;
    f_tick = 1'b1; step(); f_tick = 1'b0;
    total++; if (f_score0 !== 8'd1 || f_collect !== 1'b1) begin bad++; $display("FAIL fb_after_rst got s0=%0d col=%b want 1/1", f_score0, f_collect); end
  endtask

  initial begin
    rst = 1'b1; f_rst = 1'b1; frame_tick = 1'b0; f_tick = 1'b0;
    mario_x = 10'd0; mario_y = 10'd0; mario_x1 = 10'd0; mario_y1 = 10'd0;
    f_mx = 10'd0; f_my = 10'd0; f_mx1 = 10'd0; f_my1 = 10'd0;
    test_reset();
    test_no_overlap();
    test_edge_touch();
    test_p1_collect();
    test_tie();
    test_random();
    test_win();
    test_fallback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coin_controller.md
# coin_controller

Game-logic stage directly upstream of the VGA display stage. It owns the single coin:
- detects when either Mario overlaps it on a frame tick;
- credits the collecting player's score and hides the coin;
- waits a fixed number of frames, then respawns the coin at an LFSR-chosen legal position.

Its coin_x/coin_y outputs drive the display's coin inputs directly. Scores and game-over feed the HUD and game-control logic.

## Interface
Parameters:
- W_MARIO, 16, Mario sprite width (game units = pixels)
- H_MARIO, 16, Mario sprite height
- W_COIN, 8, coin width
- H_COIN, 8, coin height
- X_MIN / X_MAX, 10 / 580, legal coin_x range (inclusive)
- Y_MIN / Y_MAX, 0 / 200, legal coin_y range (inclusive; height above ground line)
- INIT_X / INIT_Y, 300 / 100, reset and fallback coin position
- HIDDEN_X, 1000, off-screen coin_x used while hidden (exceeds 640, so the coin is never drawn)
- RESPAWN_FRAMES, 60, frame ticks spent hidden after a collection (1..255)
- WIN_SCORE, 10, score that ends the game (1..255)
- MAX_TRIES, 64, rejected placement candidates before falling back to INIT_X/INIT_Y

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse, once per video frame
- mario_x, mario_y  in  10 each  player 0 position (lower-left corner, y above ground)
- mario_x1, mario_y1  in  10 each  player 1 position
- coin_x, coin_y  out  10 each  coin position (lower-left corner), registered
- score0, score1  out  8 each  player scores, registered
- collect  out  1  one-cycle pulse on each collection
- game_over  out  1  sticky once a player reaches WIN_SCORE
- winner  out  1  0 = player 0, 1 = player 1; valid when game_over=1

## Operation
- Overlap test, per player p, all sums 11-bit, no wrap:
  - x overlap: coin_x < px+W_MARIO and px < coin_x+W_COIN
  - y overlap: coin_y < py+H_MARIO and py < coin_y+H_COIN
  - Both conditions required; strict inequalities, so edge-touching is not overlap.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 on reset. Advances every clock in every state. Never reaches all-zero.
- State ACTIVE (reset state): on a frame_tick cycle, evaluate overlap for both players.
  - No overlap: remain in ACTIVE.
  - Overlap by player 0 only, or by both: player 0 collects. Ties go to player 0.
  - Overlap by player 1 only: player 1 collects.
  - On collection: increment that player's score; pulse collect; set coin_x=HIDDEN_X (coin_y holds).
  - If the new score equals WIN_SCORE: go to GAME_OVER and set winner. Otherwise go to COLLECTED with the frame counter cleared.
- State COLLECTED: count frame_ticks. On the tick that makes the count RESPAWN_FRAMES, go to PLACE with the try counter cleared.
- State PLACE: frame_tick is ignored. Each cycle, form a candidate: cx = {0,lfsr[9:0]}, cy = {2'b0,lfsr[15:8]}.
  - Accept when cx is in [X_MIN,X_MAX], cy is in [Y_MIN,Y_MAX], and the candidate overlaps neither Mario at current inputs.
  - On accept: load coin_x/coin_y and go to ACTIVE.
  - On reject: increment the try counter. On the MAX_TRIES-th reject, load INIT_X/INIT_Y and go to ACTIVE unconditionally; no overlap check applies to the fallback.
- State GAME_OVER: terminal. Coin stays hidden; scores, winner and game_over are frozen until rst.
- Scores never exceed WIN_SCORE, so no saturation logic is needed.

## Timing
- Reset values (asynchronous):
  - coin_x=INIT_X, coin_y=INIT_Y
  - score0=score1=0
  - collect=0, game_over=0, winner=0
  - state ACTIVE, counters 0, lfsr=16'hACE1
- Collection latency: overlap sampled on frame_tick cycle N. At edge N+1, score, coin_x=HIDDEN_X and collect=1 appear together. collect deasserts at edge N+2.
- game_over rises at the same edge as the winning score increment.
- Respawn: the state leaves COLLECTED on the RESPAWN_FRAMES-th tick after collection. The earliest visible coin is 1 cycle after entering PLACE. The worst case is MAX_TRIES cycles after entering PLACE.
- rst asserted in any state, including mid-PLACE or mid-COLLECTED, returns to reset values immediately. No pending collect pulse survives.
- Mario inputs are sampled only on frame_tick cycles (ACTIVE) and on every PLACE cycle. They are assumed stable within a frame.

## Test plan
- Reset, no overlap: Mario at (0,0), ticks x5 -> coin stays (300,100), scores 0, collect never 1.
- Player 1 collects: mario_x1=296, mario_y1=96, tick -> next cycle score1=1, coin_x=1000, collect=1 for exactly 1 cycle. Then 60 ticks -> coin reappears with X_MIN ≤ coin_x ≤ X_MAX and Y_MIN ≤ coin_y ≤ Y_MAX.
- Tie: both Marios at (300,100), tick -> score0=1, score1=0.
- Edge touch: mario_x=284 (284+16=300), mario_y=100, tick -> no collection.
- Win: collect 10 times with player 0 -> game_over=1 and winner=0 at the 10th increment. Further overlapping ticks leave score0=10 and coin_x=1000.
- Fallback: X_MIN=X_MAX=5, Y_MIN=Y_MAX=5 -> after respawn delay, PLACE exits after 64 rejects with coin=(300,100). Then assert rst mid-COLLECTED on a second run -> all outputs return to reset values.
